// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one result per op presented as a single-cycle done pulse.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            stall_req
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = '1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t              state;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic                neg_lo;     // product / quotient sign
  logic                neg_hi;     // remainder sign (follows dividend)
  logic                special_q;
  logic [XLEN-1:0]     special_res;
  logic [XLEN-1:0]     divisor_q;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       count;

  // Operand decode at issue
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_d;

  always_comb begin
    is_div    = op[2];
    a_sgn     = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn     = is_div ? ~op[0] : ~op[1];
    a_neg     = a_sgn & operand_a[XLEN-1];
    b_neg     = b_sgn & operand_b[XLEN-1];
    mag_a     = neg_x(operand_a, a_neg);
    mag_b     = neg_x(operand_b, b_neg);
    div0      = (operand_b == '0);
    ovf       = is_div & ~op[0] & (operand_a == MIN_INT) & (operand_b == ONES);
    special_d = div0 ? (op[1] ? operand_a : ONES) : (op[1] ? '0 : operand_a);
  end

  // Iteration datapath: one multiply step and one restoring-divide step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor_q} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, divisor_q});
    rem_diff = rem_sh[XLEN-1:0] - divisor_q;
    div_next = rem_ge ? {rem_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    prod     = neg_2x(mul_next, neg_lo);
    mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? neg_x(div_next[2*XLEN-1:XLEN], neg_hi)
                       : neg_x(div_next[XLEN-1:0], neg_lo);
  end

  assign stall_req = ((state == IDLE) & start & ~flush) | (state == MUL) | (state == DIV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      rd_out      <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      special_q   <= 1'b0;
      special_res <= '0;
      divisor_q   <= '0;
      acc         <= '0;
      count       <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            op_q        <= op;
            rd_q        <= rd_in;
            neg_lo      <= a_neg ^ b_neg;
            neg_hi      <= a_neg;
            acc         <= {{XLEN{1'b0}}, mag_a};
            divisor_q   <= mag_b;
            special_q   <= is_div & (div0 | ovf);
            special_res <= special_d;
            count       <= CW'(XLEN);
            state       <= is_div ? DIV : MUL;
          end
        end
        MUL: begin
          acc   <= mul_next;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= mul_res;
            rd_out <= rd_q;
          end
        end
        DIV: begin
          // Special divides spend one cycle here and skip the iteration entirely
          if (special_q) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= special_res;
            rd_out <= rd_q;
          end else begin
            acc   <= div_next;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= div_res;
              rd_out <= rd_q;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
